// File: rtl/xor_unit_rr_arbiter_pkg.sv
// Shared defaults and types for the XOR-unit round-robin arbiter and its selector.
package xor_arb_pkg;

  localparam int unsigned W   = 14;
  localparam int unsigned N   = 4;
  localparam int unsigned IDW = 2;
  localparam int unsigned CW  = 16;

  typedef logic [W-1:0]   xor_word_t;
  typedef logic [IDW-1:0] req_id_t;

  // Wrapping increment of a requester index modulo n.
  function automatic int unsigned rr_next(input int unsigned cur, input int unsigned n);
    return (cur + 1 >= n) ? 0 : cur + 1;
  endfunction

endpackage

// File: rtl/xor_unit_rr_arbiter_if.sv
// Requester, shared-XOR-unit and result-handshake bundle for xor_unit_rr_arbiter.
interface xor_unit_rr_arbiter_if
  import xor_arb_pkg::*;
#(
  parameter int unsigned W   = xor_arb_pkg::W,
  parameter int unsigned N   = xor_arb_pkg::N,
  parameter int unsigned IDW = xor_arb_pkg::IDW
);

  logic [N-1:0]   req;
  logic [N*W-1:0] a_in;
  logic [N*W-1:0] b_in;
  logic [N-1:0]   gnt;
  logic [W-1:0]   xor_a;
  logic [W-1:0]   xor_b;
  logic [W-1:0]   xor_out;
  logic           out_valid;
  logic [W-1:0]   out_data;
  logic [IDW-1:0] out_id;
  logic           out_ready;

  // Arbiter side.
  modport master (
    input  req, a_in, b_in, xor_out, out_ready,
    output gnt, xor_a, xor_b, out_valid, out_data, out_id
  );

  // Requesters, XOR unit and downstream stage.
  modport slave (
    output req, a_in, b_in, xor_out, out_ready,
    input  gnt, xor_a, xor_b, out_valid, out_data, out_id
  );

endinterface

// File: rtl/xor_unit_rr_arbiter_rr_pick.sv
// Combinational round-robin selector: first asserted req at or after ptr, wrapping mod N.
module rr_pick
  import xor_arb_pkg::*;
#(
  parameter int unsigned N   = xor_arb_pkg::N,
  parameter int unsigned IDW = xor_arb_pkg::IDW
) (
  input  logic [N-1:0]   req,
  input  logic [IDW-1:0] ptr,
  output logic [IDW-1:0] sel,
  output logic           any
);

  logic [IDW-1:0] idx;

  // Walk offsets from farthest to nearest so the nearest hit to ptr wins.
  always_comb begin
    sel = '0;
    any = 1'b0;
    idx = '0;
    for (int k = int'(N) - 1; k >= 0; k--) begin
      idx = IDW'((int'(ptr) + k) % int'(N));
      if (req[idx]) begin
        sel = idx;
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/xor_unit_rr_arbiter.sv
// Round-robin sharing of one XOR unit among N requesters with a tagged output register.
// Optional per-requester grant counters are built when XOR_ARB_STATS_EN is defined.
module xor_unit_rr_arbiter
  import xor_arb_pkg::*;
#(
  parameter int unsigned W   = xor_arb_pkg::W,
  parameter int unsigned N   = xor_arb_pkg::N,
  parameter int unsigned IDW = xor_arb_pkg::IDW
`ifdef XOR_ARB_STATS_EN
  ,
  parameter int unsigned CW  = xor_arb_pkg::CW
`endif
) (
  input  logic                  clk,
  input  logic                  rst,
  xor_unit_rr_arbiter_if.master bus
`ifdef XOR_ARB_STATS_EN
  ,
  input  logic                  stat_clr,
  output logic [N*CW-1:0]       stat_cnt
`endif
);

  logic [W-1:0]   a_word [N];
  logic [W-1:0]   b_word [N];

  logic [IDW-1:0] sel;
  logic           any;
  logic           can_accept;
  logic           grant;

  logic           out_valid_q, out_valid_d;
  logic [W-1:0]   out_data_q,  out_data_d;
  logic [IDW-1:0] out_id_q,    out_id_d;
  logic [IDW-1:0] ptr_q,       ptr_d;

  for (genvar i = 0; i < N; i++) begin : g_unpack
    assign a_word[i] = bus.a_in[i*W +: W];
    assign b_word[i] = bus.b_in[i*W +: W];
  end

  rr_pick #(
    .N   (N),
    .IDW (IDW)
  ) u_rr_pick (
    .req (bus.req),
    .ptr (ptr_q),
    .sel (sel),
    .any (any)
  );

  // A full register frees up in the same cycle it drains, giving back-to-back grants.
  assign can_accept = !out_valid_q || bus.out_ready;
  assign grant      = any && can_accept;

  // Operands follow the selection even while stalled so the unit output is already settled.
  assign bus.xor_a = any ? a_word[sel] : '0;
  assign bus.xor_b = any ? b_word[sel] : '0;
  assign bus.gnt   = grant ? (N'(1) << sel) : '0;

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_id_d    = out_id_q;
    ptr_d       = ptr_q;
    if (grant) begin
      out_valid_d = 1'b1;
      out_data_d  = bus.xor_out;
      out_id_d    = sel;
      ptr_d       = IDW'(rr_next(32'(sel), N));
    end else if (out_valid_q && bus.out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_id_q    <= '0;
      ptr_q       <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_id_q    <= out_id_d;
      ptr_q       <= ptr_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_id    = out_id_q;

`ifdef XOR_ARB_STATS_EN
  localparam logic [CW-1:0] CntMax = '1;

  logic [CW-1:0] cnt_q [N];

  // Clear wins over a same-cycle grant; counts stick at all-ones.
  always_ff @(posedge clk) begin
    for (int i = 0; i < int'(N); i++) begin
      if (rst || stat_clr) begin
        cnt_q[i] <= '0;
      end else if (bus.gnt[i] && (cnt_q[i] != CntMax)) begin
        cnt_q[i] <= cnt_q[i] + CW'(1);
      end
    end
  end

  for (genvar i = 0; i < N; i++) begin : g_stat_pack
    assign stat_cnt[i*CW +: CW] = cnt_q[i];
  end
`endif

endmodule

// File: tb/tb_xor_unit_rr_arbiter.sv
// Table-driven directed vectors plus randomized traffic against a behavioural model.
module tb_xor_unit_rr_arbiter;
  import xor_arb_pkg::*;

  localparam int unsigned TbCw = 2;

  logic clk = 1'b0;
  logic rst;
  logic stat_clr;
`ifdef XOR_ARB_STATS_EN
  logic [N*TbCw-1:0] stat_cnt;
`endif

  always #5 clk = ~clk;

  xor_unit_rr_arbiter_if #(.W(W), .N(N), .IDW(IDW)) ifc ();

  // Behaviour of the shared combinational XOR unit.
  assign ifc.xor_out = ifc.xor_a ^ ifc.xor_b;

  xor_unit_rr_arbiter #(
    .W   (W),
    .N   (N),
    .IDW (IDW)
`ifdef XOR_ARB_STATS_EN
    ,
    .CW  (TbCw)
`endif
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (ifc)
`ifdef XOR_ARB_STATS_EN
    ,
    .stat_clr (stat_clr),
    .stat_cnt (stat_cnt)
`endif
  );

  int total = 0;
  int bad   = 0;

  // Stimulus state.
  logic         s_rst, s_rdy, s_clr;
  logic [N-1:0] s_req;
  xor_word_t    a_arr [N];
  xor_word_t    b_arr [N];

  // Sampled DUT outputs.
  logic [N-1:0] g_gnt;
  xor_word_t    g_xa, g_xb, g_data;
  logic         g_vld;
  req_id_t      g_id;
  logic [63:0]  g_cnt;

  // Reference model.
  logic         m_valid;
  xor_word_t    m_data;
  int           m_id, m_ptr;
  int           m_cnt [N];
  int           e_sel;
  logic         e_grant;
  logic [N-1:0] e_gnt;
  xor_word_t    e_xa, e_xb;

  typedef struct {
    logic         rst;
    logic [3:0]   req;
    logic         rdy;
    logic [3:0]   gnt;
    xor_word_t    xa;
    xor_word_t    xb;
    logic         vld;
    req_id_t      id;
    xor_word_t    data;
  } vec_t;

  vec_t vt [20];

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", nm, got, exp, $time);
    end
  endtask

  task automatic model_comb();
    e_sel = -1;
    for (int k = 0; k < int'(N); k++) begin
      int i;
      i = (m_ptr + k) % int'(N);
      if (s_req[i] && e_sel < 0) e_sel = i;
    end
    e_grant = (e_sel >= 0) && (!m_valid || s_rdy);
    e_gnt   = e_grant ? N'(1 << e_sel) : '0;
    e_xa    = (e_sel >= 0) ? a_arr[e_sel] : '0;
    e_xb    = (e_sel >= 0) ? b_arr[e_sel] : '0;
  endtask

  task automatic model_seq();
    int cmax;
    cmax = (1 << TbCw) - 1;
    if (s_rst) begin
      m_valid = 1'b0;
      m_data  = '0;
      m_id    = 0;
      m_ptr   = 0;
      for (int i = 0; i < int'(N); i++) m_cnt[i] = 0;
    end else begin
      if (e_grant) begin
        m_valid = 1'b1;
        m_data  = a_arr[e_sel] ^ b_arr[e_sel];
        m_id    = e_sel;
        m_ptr   = (e_sel + 1) % int'(N);
      end else if (m_valid && s_rdy) begin
        m_valid = 1'b0;
      end
      for (int i = 0; i < int'(N); i++) begin
        if (s_clr) m_cnt[i] = 0;
        else if (e_grant && e_sel == i && m_cnt[i] < cmax) m_cnt[i]++;
      end
    end
  endtask

  // Called just after a falling edge; returns just after the next falling edge.
  task automatic tick();
    rst           = s_rst;
    stat_clr      = s_clr;
    ifc.req       = s_req;
    ifc.out_ready = s_rdy;
    for (int i = 0; i < int'(N); i++) begin
      ifc.a_in[i*W +: W] = a_arr[i];
      ifc.b_in[i*W +: W] = b_arr[i];
    end
    #1;
    g_gnt = ifc.gnt;
    g_xa  = ifc.xor_a;
    g_xb  = ifc.xor_b;
    model_comb();
    @(posedge clk);
    model_seq();
    #1;
    g_vld  = ifc.out_valid;
    g_data = ifc.out_data;
    g_id   = ifc.out_id;
`ifdef XOR_ARB_STATS_EN
    g_cnt  = 64'(stat_cnt);
`else
    g_cnt  = '0;
`endif
    @(negedge clk);
  endtask

  initial begin
    s_rst = 1'b1; s_rdy = 1'b1; s_clr = 1'b0; s_req = '0;
    a_arr[0] = 14'h0001; b_arr[0] = 14'h0010;
    a_arr[1] = 14'h0100; b_arr[1] = 14'h0003;
    a_arr[2] = 14'h3FFF; b_arr[2] = 14'h1555;
    a_arr[3] = 14'h2000; b_arr[3] = 14'h0F0F;
    m_valid = 1'b0; m_data = '0; m_id = 0; m_ptr = 0;
    for (int i = 0; i < int'(N); i++) m_cnt[i] = 0;

    //            rst   req      rdy   gnt      xa        xb        vld   id    data
    vt[0]  = '{1'b1, 4'b0000, 1'b1, 4'b0000, 14'h0000, 14'h0000, 1'b0, 2'd0, 14'h0000};
    vt[1]  = '{1'b0, 4'b0100, 1'b1, 4'b0100, 14'h3FFF, 14'h1555, 1'b1, 2'd2, 14'h2AAA};
    vt[2]  = '{1'b0, 4'b1111, 1'b1, 4'b1000, 14'h2000, 14'h0F0F, 1'b1, 2'd3, 14'h2F0F};
    for (int r = 0; r < 2; r++) begin
      vt[3+4*r] = '{1'b0, 4'b1111, 1'b1, 4'b0001, 14'h0001, 14'h0010, 1'b1, 2'd0, 14'h0011};
      vt[4+4*r] = '{1'b0, 4'b1111, 1'b1, 4'b0010, 14'h0100, 14'h0003, 1'b1, 2'd1, 14'h0103};
      vt[5+4*r] = '{1'b0, 4'b1111, 1'b1, 4'b0100, 14'h3FFF, 14'h1555, 1'b1, 2'd2, 14'h2AAA};
      vt[6+4*r] = '{1'b0, 4'b1111, 1'b1, 4'b1000, 14'h2000, 14'h0F0F, 1'b1, 2'd3, 14'h2F0F};
    end
    for (int r = 11; r < 14; r++)
      vt[r]  = '{1'b0, 4'b0011, 1'b0, 4'b0000, 14'h0001, 14'h0010, 1'b1, 2'd3, 14'h2F0F};
    vt[14] = '{1'b0, 4'b0011, 1'b1, 4'b0001, 14'h0001, 14'h0010, 1'b1, 2'd0, 14'h0011};
    vt[15] = '{1'b0, 4'b0000, 1'b1, 4'b0000, 14'h0000, 14'h0000, 1'b0, 2'd0, 14'h0011};
    vt[16] = '{1'b0, 4'b0000, 1'b1, 4'b0000, 14'h0000, 14'h0000, 1'b0, 2'd0, 14'h0011};
    vt[17] = '{1'b0, 4'b0010, 1'b1, 4'b0010, 14'h0100, 14'h0003, 1'b1, 2'd1, 14'h0103};
    vt[18] = '{1'b1, 4'b1111, 1'b1, 4'b0100, 14'h3FFF, 14'h1555, 1'b0, 2'd0, 14'h0000};
    vt[19] = '{1'b0, 4'b1111, 1'b1, 4'b0001, 14'h0001, 14'h0010, 1'b1, 2'd0, 14'h0011};

    @(negedge clk);
    tick();
    tick();
    chk("reset_valid", 64'(g_vld), 64'd0);
    chk("reset_data", 64'(g_data), 64'd0);
    chk("reset_id", 64'(g_id), 64'd0);

    for (int v = 0; v < 20; v++) begin
      s_rst = vt[v].rst;
      s_req = vt[v].req;
      s_rdy = vt[v].rdy;
      tick();
      chk($sformatf("vec%0d_gnt", v), 64'(g_gnt), 64'(vt[v].gnt));
      chk($sformatf("vec%0d_xa", v), 64'(g_xa), 64'(vt[v].xa));
      chk($sformatf("vec%0d_xb", v), 64'(g_xb), 64'(vt[v].xb));
      chk($sformatf("vec%0d_valid", v), 64'(g_vld), 64'(vt[v].vld));
      chk($sformatf("vec%0d_id", v), 64'(g_id), 64'(vt[v].id));
      chk($sformatf("vec%0d_data", v), 64'(g_data), 64'(vt[v].data));
    end

`ifdef XOR_ARB_STATS_EN
    s_rst = 1'b1; s_req = '0; s_rdy = 1'b1; s_clr = 1'b0;
    tick();
    s_rst = 1'b0;
    s_req = 4'b0010;
    repeat (5) tick();
    chk("stat_sat_r1", g_cnt[1*TbCw +: TbCw], 64'd3);
    chk("stat_sat_r0", g_cnt[0*TbCw +: TbCw], 64'd0);
    s_req = '0; s_clr = 1'b1;
    tick();
    chk("stat_clr", g_cnt[1*TbCw +: TbCw], 64'd0);
    s_clr = 1'b0; s_req = 4'b0010;
    tick();
    chk("stat_one", g_cnt[1*TbCw +: TbCw], 64'd1);
    s_clr = 1'b1;
    tick();
    chk("stat_clr_vs_gnt", g_cnt[1*TbCw +: TbCw], 64'd0);
    s_clr = 1'b0;
`endif

    s_rst = 1'b1; s_req = '0;
    tick();
    s_rst = 1'b0;
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < int'(N); i++) begin
        if (e_grant && e_sel == i && !s_rst) begin
          s_req[i] = 1'($urandom_range(0, 1));
          a_arr[i] = xor_word_t'($urandom);
          b_arr[i] = xor_word_t'($urandom);
        end else if (s_req[i]) begin
          if ($urandom_range(0, 19) == 0) s_req[i] = 1'b0;
        end else if ($urandom_range(0, 2) == 0) begin
          s_req[i] = 1'b1;
          a_arr[i] = xor_word_t'($urandom);
          b_arr[i] = xor_word_t'($urandom);
        end
      end
      s_rdy = ($urandom_range(0, 9) < 7);
      s_rst = ($urandom_range(0, 49) == 0);
      s_clr = ($urandom_range(0, 29) == 0);
      tick();
      chk("rand_gnt", 64'(g_gnt), 64'(e_gnt));
      chk("rand_xa", 64'(g_xa), 64'(e_xa));
      chk("rand_xb", 64'(g_xb), 64'(e_xb));
      chk("rand_valid", 64'(g_vld), 64'(m_valid));
      chk("rand_id", 64'(g_id), 64'(m_id));
      chk("rand_data", 64'(g_data), 64'(m_data));
`ifdef XOR_ARB_STATS_EN
      for (int i = 0; i < int'(N); i++)
        chk($sformatf("rand_cnt%0d", i), g_cnt[i*TbCw +: TbCw], 64'(m_cnt[i]));
`endif
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/xor_unit_rr_arbiter.md
Name: xor_unit_rr_arbiter

Overview:
- Round-robin arbiter and sequencer sharing one combinational W-bit XOR datapath unit among N requesters in the decoder pipeline.
- Selects one requester per cycle and drives that requester's operands onto the shared unit.
- Captures the XOR result in an output register tagged with the requester ID.
- Output register has a valid/ready handshake toward the downstream decoder stage.

Parameters:
- W, 14, operand/result width in bits
- N, 4, number of requesters (2..8)
- IDW, 2, requester ID width; must equal clog2(N)
- CW, 16, per-requester grant counter width (optional feature only)

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous active-high reset
- req  in  N  req[i]=1: requester i has a pending operation
- a_in  in  N*W  operand A, requester i at bits [i*W +: W]
- b_in  in  N*W  operand B, same packing as a_in
- gnt  out  N  one-hot accept pulse, combinational, same cycle as capture
- xor_a  out  W  operand A driven to shared XOR unit
- xor_b  out  W  operand B driven to shared XOR unit
- xor_out  in  W  result returned from shared XOR unit (combinational)
- out_valid  out  1  result register holds valid data
- out_data  out  W  captured result
- out_id  out  IDW  index of the requester that produced out_data
- out_ready  in  1  downstream accepts result when out_valid&out_ready

Behaviour:
- Decided interface: one clock, clk; reset is rst, synchronous and active-high.
- Reset values: out_valid=0, out_data=0, out_id=0, round-robin pointer ptr=0, all grant counters=0.
- Capacity signal: can_accept = !out_valid | out_ready. This allows one result per cycle with full throughput.
- Selection: sel = first i with req[i]=1, searching ptr, ptr+1, …, N-1, 0, …, ptr-1 (mod N).
- Operand drive: xor_a/xor_b = a_in/b_in slice of sel whenever any req is set, regardless of can_accept. When no req is set, they are driven to 0.
- gnt[sel]=1 only when |req & can_accept. Otherwise gnt=0. gnt is never multi-hot.
- On a grant edge:
  - out_data<=xor_out, out_id<=sel, out_valid<=1
  - ptr<=(sel+1) mod N
- Drain without a new grant: out_valid&out_ready&!(|req) -> out_valid<=0. out_data and out_id hold their last values.
- Stall: out_valid&!out_ready -> no grant; out_data, out_id and ptr hold; requesters keep req and operands stable.
- Latency: operands to out_valid = 1 cycle. Sustained throughput = 1 op/cycle while out_ready=1.
- Fairness: a continuously requesting requester is granted within N grants.
- Requester rule: the requester deasserts or changes req[i]/operands only in the cycle after gnt[i]. A req dropped before grant is legal and is simply skipped.
- Reset mid-operation: a pending out_valid result is discarded and ptr returns to 0. rst has priority over every other update in the same cycle.

Optional Feature:
- Macro: XOR_ARB_STATS_EN
- Defined:
  - Adds ports stat_clr (in, 1) and stat_cnt (out, N*CW).
  - Per-requester counter increments on each gnt[i] and saturates at 2^CW-1.
  - stat_clr=1 zeroes all counters. stat_clr has priority over a same-cycle increment.
  - rst also zeroes all counters.
- Undefined: no ports, counters or logic are added; arbiter behaviour is identical.

Decomposition:
- Shared package xor_arb_pkg:
  - W, N, IDW, CW defaults
  - typedef xor_word_t (logic [W-1:0])
  - typedef req_id_t (logic [IDW-1:0])
- Sub-module rr_pick: combinational round-robin selector.
  - Inputs: req, ptr. Outputs: sel, any.
  - Reusable by other shared-datapath controllers in the decoder.

Test Plan:
- Single request: rst, then req=4'b0100, a_in[2]=14'h3FFF, b_in[2]=14'h1555, out_ready=1.
  - Same cycle: gnt=4'b0100, xor_a=14'h3FFF.
  - Next cycle: out_valid=1, out_data=14'h2AAA, out_id=2, ptr=3.
- All request continuously, out_ready=1, 8 cycles:
  - Grant order 0,1,2,3,0,1,2,3; out_id follows one cycle later; out_valid stays 1.
- Backpressure: out_valid=1, out_ready=0 for 3 cycles with req=4'b0011.
  - gnt=0 and out_data stable for all 3 cycles.
  - When out_ready rises, requester 0 (ptr=0) is granted that cycle.
- Drain then idle: last grant, then req=0 and out_ready=1.
  - Next cycle out_valid=0; xor_a=0, xor_b=0.
- Reset mid-stream: rst=1 while out_valid=1 and ptr=2.
  - Next cycle out_valid=0, out_data=0, out_id=0, ptr=0.
  - First grant after rst with req=4'b1111 goes to requester 0.
- XOR_ARB_STATS_EN, CW=2: requester 1 alone granted 5 times -> stat_cnt[1]=3 (saturated).
  - stat_clr pulse -> 0.
  - stat_clr and a grant in the same cycle -> 0.
